// File: rtl/perf_pkg.sv
// rtl/perf_pkg.sv - shared constants for the performance counter bank
package perf_pkg;

  localparam int PERF_WRAP = 0;
  localparam int PERF_SAT  = 1;

  localparam int PERF_NUM_CH_DEF = 4;
  localparam int PERF_CNT_W_DEF  = 32;

endpackage

// File: rtl/perf_counter.sv
// rtl/perf_counter.sv - one event counter channel: clear > write > increment, sticky overflow
// Optional shadow snapshot register when PERF_SNAPSHOT_EN is defined.
module perf_counter
  import perf_pkg::*;
#(
  parameter int CNT_W    = PERF_CNT_W_DEF,
  parameter int SAT_MODE = PERF_WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic             clear,
  input  logic             evt,
  input  logic             wr_hit,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             snap,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (clear) begin
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (wr_hit) begin
      cnt_d = wr_data;
      ovf_d = 1'b0;
    end else if (evt && !pause) begin
      if (&cnt_q) begin
        cnt_d = (SAT_MODE == PERF_SAT) ? cnt_q : '0;
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt = cnt_q;
  assign ovf = ovf_q;

`ifdef PERF_SNAPSHOT_EN
  logic [CNT_W-1:0] shadow_q, shadow_d;

  // Copies the pre-update count, so a same-cycle clear, write or increment is not captured.
  always_comb begin
    shadow_d = shadow_q;
    if (snap) shadow_d = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow_q <= '0;
    else     shadow_q <= shadow_d;
  end

  assign shadow = shadow_q;
`else
  logic unused_snap;
  assign unused_snap = snap;
  assign shadow      = '0;
`endif

endmodule

// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of NUM_CH event counters with preset write and registered readout
// PERF_SNAPSHOT_EN adds per-channel shadow registers selectable through rd_shadow.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int  NUM_CH   = PERF_NUM_CH_DEF,
  parameter int  CNT_W    = PERF_CNT_W_DEF,
  parameter int  SAT_MODE = PERF_WRAP,
  localparam int SEL_W    = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pause,
  input  logic              clear,
  input  logic [NUM_CH-1:0] evt,
  input  logic              wr_en,
  input  logic [SEL_W-1:0]  wr_sel,
  input  logic [CNT_W-1:0]  wr_data,
  input  logic [SEL_W-1:0]  rd_sel,
  input  logic              rd_shadow,
  input  logic              snap,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf
);

`ifdef PERF_SNAPSHOT_EN
  localparam bit SHADOW_EN = 1'b1;
`else
  localparam bit SHADOW_EN = 1'b0;
`endif

  logic [CNT_W-1:0] cnt_all    [NUM_CH];
  logic [CNT_W-1:0] shadow_all [NUM_CH];
  logic [CNT_W-1:0] rd_data_q, rd_data_d;

  // Out-of-range wr_sel matches no channel, so such writes fall away naturally.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    perf_counter #(
      .CNT_W    (CNT_W),
      .SAT_MODE (SAT_MODE)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .pause   (pause),
      .clear   (clear),
      .evt     (evt[i]),
      .wr_hit  (wr_en && (wr_sel == SEL_W'(i))),
      .wr_data (wr_data),
      .snap    (snap),
      .cnt     (cnt_all[i]),
      .shadow  (shadow_all[i]),
      .ovf     (ovf[i])
    );
  end

  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_data_d = (SHADOW_EN && rd_shadow) ? shadow_all[i] : cnt_all[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_q <= '0;
    else     rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule
